// File: rtl/tl_bypass_pkg.sv
// Shared types and constants for the TileLink bypass sequencer.
// The A payload is packed as {opcode, address, data}, with opcode in the MSBs.
package tl_bypass_pkg;

  typedef enum logic [1:0] {
    PASS       = 2'd0,
    BYP        = 2'd1,
    DRAIN_PASS = 2'd2,
    DRAIN_BYP  = 2'd3
  } state_t;

  localparam int OPCODE_W   = 3;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 32;
  localparam int DATA_LSB   = 0;
  localparam int ADDR_LSB   = DATA_LSB + DATA_W;
  localparam int OPCODE_LSB = ADDR_LSB + ADDR_W;
  localparam int A_BITS     = OPCODE_W + ADDR_W + DATA_W;

  localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/tl_outstanding_counter.sv
// Tracks in-flight single-beat A requests that have no D response yet.
// The count saturates at MAX_OUTSTANDING, and a D fire at zero raises a sticky underflow flag.
module tl_outstanding_counter #(
  parameter int MAX_OUTSTANDING = 4,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          a_fire,
  input  logic          d_fire,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          underflow_err
);

  assign full = (count == CW'(MAX_OUTSTANDING));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count         <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (d_fire && count == '0) underflow_err <= 1'b1;
      case ({a_fire, d_fire})
        2'b10: if (!full) count <= count + 1'b1;
        2'b01: if (count != '0) count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tl_bypass_sequencer.sv
// Sequences bypass-switch select changes: it gates new A requests, drains in-flight requests, then flips io_bypass.
// A drain that outlives TIMEOUT cycles aborts back to the source select and sets timeout_err.
module tl_bypass_sequencer
  import tl_bypass_pkg::*;
#(
  parameter int ABITS           = A_BITS,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = DEFAULT_TIMEOUT,
  parameter bit RESET_BYPASS    = 1'b1,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_a_valid,
  output logic             in_a_ready,
  input  logic [ABITS-1:0] in_a_bits,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [ABITS-1:0] out_a_bits,
  input  logic             d_valid,
  input  logic             d_ready,
  input  logic             cmd_valid,
  input  logic             cmd_bypass,
  output logic             cmd_ready,
  output logic             io_bypass,
  output logic             done,
  output logic             timeout_err,
  output logic             underflow_err,
  output logic [CW-1:0]    outstanding
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam state_t RESET_STATE = RESET_BYPASS ? BYP : PASS;

  state_t        state;
  logic [TW-1:0] drain_timer;
  logic          stable;
  logic          open;
  logic          full;
  logic          a_fire;
  logic          d_fire;
  logic          cmd_accept;

  // Valid/ready: a beat transfers on a cycle where valid and ready are both high.
  // Valid never waits on ready. Closing the gate drops valid and ready together, so no beat leaks through.
  assign stable      = (state == PASS) || (state == BYP);
  assign open        = stable && !full;
  assign out_a_valid = in_a_valid && open;
  assign in_a_ready  = out_a_ready && open;
  assign out_a_bits  = in_a_bits;
  assign cmd_ready   = stable;
  assign cmd_accept  = cmd_valid && stable;
  assign a_fire      = out_a_valid && out_a_ready;
  assign d_fire      = d_valid && d_ready;

  tl_outstanding_counter #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_counter (
    .clock         (clock),
    .reset         (reset),
    .a_fire        (a_fire),
    .d_fire        (d_fire),
    .count         (outstanding),
    .full          (full),
    .underflow_err (underflow_err)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RESET_STATE;
      io_bypass   <= RESET_BYPASS;
      drain_timer <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        PASS, BYP: begin
          if (cmd_accept) begin
            timeout_err <= 1'b0;
            if (cmd_bypass == io_bypass) begin
              done <= 1'b1;
            end else begin
              state       <= cmd_bypass ? DRAIN_BYP : DRAIN_PASS;
              drain_timer <= '0;
            end
          end
        end
        default: begin
          // io_bypass still holds the source select for the whole drain.
          if (outstanding == '0) begin
            state     <= (state == DRAIN_BYP) ? BYP : PASS;
            io_bypass <= (state == DRAIN_BYP);
            done      <= 1'b1;
          end else if (TIMEOUT != 0 && drain_timer == T_LAST) begin
            state       <= io_bypass ? BYP : PASS;
            timeout_err <= 1'b1;
            done        <= 1'b1;
          end else begin
            drain_timer <= drain_timer + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tl_bypass_sequencer.sv
// Directed test of tl_bypass_sequencer with hand-computed expectations.
// Inputs are driven 2 time units after each rising edge, and outputs are sampled 1 time unit later.
module tb_tl_bypass_sequencer;

  localparam int ABITS = 44;
  localparam int CW    = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_a_valid;
  logic             in_a_ready;
  logic [ABITS-1:0] in_a_bits;
  logic             out_a_valid;
  logic             out_a_ready;
  logic [ABITS-1:0] out_a_bits;
  logic             d_valid;
  logic             d_ready;
  logic             cmd_valid;
  logic             cmd_bypass;
  logic             cmd_ready;
  logic             io_bypass;
  logic             done;
  logic             timeout_err;
  logic             underflow_err;
  logic [CW-1:0]    outstanding;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CW-1:0] exp_q[$];

  tl_bypass_sequencer #(
    .ABITS(ABITS), .MAX_OUTSTANDING(4), .TIMEOUT(8), .RESET_BYPASS(1'b1)
  ) dut (
    .clock(clock), .reset(reset),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_bits(in_a_bits),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_bits(out_a_bits),
    .d_valid(d_valid), .d_ready(d_ready),
    .cmd_valid(cmd_valid), .cmd_bypass(cmd_bypass), .cmd_ready(cmd_ready),
    .io_bypass(io_bypass), .done(done), .timeout_err(timeout_err),
    .underflow_err(underflow_err), .outstanding(outstanding)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic send_cmd(input logic sel);
    cmd_valid  = 1'b1;
    cmd_bypass = sel;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic a_fires(input int n);
    in_a_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_a_bits = {3'd4, 9'(i), 32'hA5A5_0000 + 32'(i)};
      tick();
    end
    in_a_valid = 1'b0;
  endtask

  task automatic d_fires(input int n);
    d_valid = 1'b1;
    for (int i = 0; i < n; i++) tick();
    d_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; in_a_valid = 1'b0; in_a_bits = '0; out_a_ready = 1'b1;
    d_valid = 1'b0; d_ready = 1'b1; cmd_valid = 1'b0; cmd_bypass = 1'b0;
    #12;
    check("rst_io_bypass", io_bypass, 1);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_underflow_err", underflow_err, 0);
    check("rst_outstanding", outstanding, 0);
    #10 reset = 1'b1;
    tick();

    // A payload is wired straight through.
    in_a_bits = 44'hABC_DEAD_BEEF;
    settle();
    check("bits_passthru", out_a_bits, 44'hABC_DEAD_BEEF);

    // Switch BYP -> PASS with no traffic.
    send_cmd(1'b0);
    settle();
    check("s1_drain_io_bypass", io_bypass, 1);
    check("s1_drain_cmd_ready", cmd_ready, 0);
    check("s1_drain_done", done, 0);
    tick();
    check("s1_io_bypass_fell", io_bypass, 0);
    check("s1_done", done, 1);
    check("s1_cmd_ready", cmd_ready, 1);
    tick();
    check("s1_done_once", done, 0);

    // Three A fires, then switch PASS -> BYP; A stays gated until D responses drain the count.
    a_fires(3);
    check("s2_outstanding3", outstanding, 3);
    send_cmd(1'b1);
    in_a_valid = 1'b1;
    settle();
    check("s2_gated_in_a_ready", in_a_ready, 0);
    check("s2_gated_out_a_valid", out_a_valid, 0);
    check("s2_cmd_ready", cmd_ready, 0);
    check("s2_outstanding_held", outstanding, 3);
    exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0);
    d_valid = 1'b1;
    while (exp_q.size() > 0) begin
      tick();
      check("s2_drain_count", outstanding, exp_q.pop_front());
    end
    d_valid = 1'b0;
    check("s2_still_gated", in_a_ready, 0);
    check("s2_io_bypass_before", io_bypass, 0);
    in_a_valid = 1'b0;
    tick();
    check("s2_io_bypass_flip", io_bypass, 1);
    check("s2_done", done, 1);
    check("s2_reopen", in_a_ready, 1);

    // Fill to MAX_OUTSTANDING; one D fire releases backpressure.
    a_fires(4);
    in_a_valid = 1'b1;
    settle();
    check("s3_outstanding4", outstanding, 4);
    check("s3_full_in_a_ready", in_a_ready, 0);
    check("s3_full_out_a_valid", out_a_valid, 0);
    d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    in_a_valid = 1'b0;
    settle();
    check("s3_after_d_count", outstanding, 3);
    check("s3_after_d_ready", in_a_ready, 1);
    d_fires(3);
    check("s3_drained", outstanding, 0);

    // Simultaneous A and D fire, then an underflow.
    a_fires(2);
    check("s5_count2", outstanding, 2);
    in_a_valid = 1'b1; d_valid = 1'b1;
    tick();
    in_a_valid = 1'b0; d_valid = 1'b0;
    check("s5_both_fire", outstanding, 2);
    d_fires(2);
    check("s5_zero", outstanding, 0);
    check("s5_no_underflow_yet", underflow_err, 0);
    d_fires(1);
    check("s5_underflow_err", underflow_err, 1);
    check("s5_underflow_count", outstanding, 0);

    // Drain timeout: one request never answered.
    a_fires(1);
    send_cmd(1'b0);
    for (int i = 0; i < 7; i++) tick();
    check("s4_still_draining", cmd_ready, 0);
    check("s4_no_err_yet", timeout_err, 0);
    tick();
    check("s4_abort_cmd_ready", cmd_ready, 1);
    check("s4_abort_io_bypass", io_bypass, 1);
    check("s4_timeout_err", timeout_err, 1);
    check("s4_abort_done", done, 1);
    check("s4_still_outstanding", outstanding, 1);
    tick();
    check("s4_done_pulse", done, 0);
    check("s4_err_sticky", timeout_err, 1);
    send_cmd(1'b1);
    check("s4_err_cleared", timeout_err, 0);
    check("s4_same_cmd_done", done, 1);
    check("s4_same_cmd_sel", io_bypass, 1);
    check("s4_same_cmd_ready", cmd_ready, 1);

    // Reset asserted mid-drain with two outstanding.
    a_fires(1);
    check("s6_count2", outstanding, 2);
    send_cmd(1'b0);
    tick();
    check("s6_in_drain", cmd_ready, 0);
    reset = 1'b0;
    #1;
    check("s6_rst_outstanding", outstanding, 0);
    check("s6_rst_io_bypass", io_bypass, 1);
    check("s6_rst_cmd_ready", cmd_ready, 1);
    check("s6_rst_underflow", underflow_err, 0);
    #10 reset = 1'b1;
    tick();
    check("s6_post_cmd_ready", cmd_ready, 1);
    check("s6_post_io_bypass", io_bypass, 1);
    check("s6_post_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_bypass_sequencer.md
Name: tl_bypass_sequencer

Overview:
- Controller in front of the TileLink bus-bypass switch; owns the switch's `io_bypass` select.
- Accepts switch commands from a control register. It first gates new A-channel requests, then drains outstanding transactions to zero, and only then flips the select, so no transaction ever straddles a switch.
- Sits between the upstream TL client port and the bypass switch's inbound node. D channel passes through ungated.

Parameters:
- ABITS, 44, packed A-channel payload width (opcode 3 + address 9 + data 32).
- MAX_OUTSTANDING, 4, maximum in-flight A requests without a D response.
- TIMEOUT, 1024, drain cycles before abort; 0 disables the timeout.
- RESET_BYPASS, 1, select value (and matching stable state) after reset.

Ports:
- clock  in  1  the single clock.
- reset  in  1  asynchronous, active-low reset.
- in_a_valid  in  1  upstream A valid.
- in_a_ready  out  1  upstream A ready.
- in_a_bits  in  ABITS  upstream A payload.
- out_a_valid  out  1  A valid toward the bypass switch.
- out_a_ready  in  1  A ready from the bypass switch.
- out_a_bits  out  ABITS  A payload toward the bypass switch (wired through).
- d_valid  in  1  D valid (monitored only).
- d_ready  in  1  D ready (monitored only).
- cmd_valid  in  1  switch command strobe.
- cmd_bypass  in  1  requested select value.
- cmd_ready  out  1  high in stable states.
- io_bypass  out  1  registered select to the bypass switch.
- done  out  1  one-cycle pulse when a command completes.
- timeout_err  out  1  sticky: the last drain was aborted.
- underflow_err  out  1  sticky: a D fire occurred with count 0.
- outstanding  out  clog2(MAX_OUTSTANDING+1)  current in-flight count.

Behaviour:
- Reset values:
  - state = RESET_BYPASS ? BYP : PASS
  - io_bypass = RESET_BYPASS
  - count = 0, drain timer = 0
  - done = 0, timeout_err = 0, underflow_err = 0
- Fire definitions: a_fire = out_a_valid & out_a_ready; d_fire = d_valid & d_ready. All transactions are single-beat.
- Counter updates:
  - a_fire only: +1.
  - d_fire only: −1.
  - Both in the same cycle: unchanged.
  - d_fire with count 0: count stays 0 and underflow_err is set.
- A gating (combinational): open = (state ∈ {PASS, BYP}) & (count < MAX_OUTSTANDING).
  - out_a_valid = in_a_valid & open
  - in_a_ready = out_a_ready & open
  - At count == MAX_OUTSTANDING, A is backpressured until a D fire.
- FSM states: PASS, BYP, DRAIN_PASS (heading to PASS), DRAIN_BYP (heading to BYP).
- cmd_ready = state ∈ {PASS, BYP}. A command is accepted on cmd_valid & cmd_ready.
  - Accepting a command clears timeout_err. underflow_err is cleared only by reset.
- Command equal to the current select: the state is unchanged and done pulses on the next cycle.
- Command differing from the current select:
  - Next state is DRAIN_<target>, and the drain timer loads 0.
  - A is gated from the next cycle.
  - Any A fire in the accept cycle itself is counted.
- In DRAIN_x when count == 0:
  - Next cycle: state = x, io_bypass = (x == BYP), done = 1.
  - A gating reopens in that same cycle.
- In DRAIN_x when count > 0: the timer increments.
  - If TIMEOUT ≠ 0 and the timer reaches TIMEOUT−1 with count still > 0, abort.
  - Abort: next cycle, state returns to the source stable state, io_bypass is unchanged, timeout_err = 1, done = 1.
- io_bypass changes only on the PASS↔BYP transitions described above, never combinationally.
- Outstanding transactions that are still unanswered after an abort remain counted.
- Asserting reset at any point returns every register to its reset value asynchronously. In-flight counts are discarded, and the bench must quiesce the bus around reset.

Decomposition:
- Package tl_bypass_pkg holds:
  - state enum (PASS, BYP, DRAIN_PASS, DRAIN_BYP)
  - A payload field widths and offsets (opcode 3, address 9, data 32)
  - default TIMEOUT constant
- Sub-module tl_outstanding_counter holds the saturating up/down count, the full flag and the underflow detect. Parameter: MAX_OUTSTANDING.
- The FSM, drain timer and A gating stay in tl_bypass_sequencer.

Test Plan:
- Reset with RESET_BYPASS=1, then cmd_bypass=0 with no traffic → io_bypass falls 2 cycles after accept, done pulses once, cmd_ready is low for 1 cycle.
- Issue 3 A fires (no D), then cmd_bypass toggle → A is gated (in_a_ready=0). After 3 D fires, outstanding=0; io_bypass flips the next cycle and A reopens.
- 4 A fires with no D → in_a_ready=0 at outstanding=4. One D fire → in_a_ready returns the following cycle.
- TIMEOUT=8, 1 outstanding, never responded, then switch command → after 8 drain cycles: state returns to source, io_bypass unchanged, timeout_err=1, done pulse. The next accepted command clears timeout_err.
- Simultaneous A fire and D fire at count 2 → count stays 2. D fire at count 0 → underflow_err=1 and count stays 0.
- Reset asserted mid-DRAIN with count 2 → immediately state = reset state, count=0, io_bypass=RESET_BYPASS, cmd_ready=1 after release.
